trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Controller-side initiator for the machine-mode CSR exception interface: on a trap request from the core it issues the fixed CSR access sequence (write MEPC, write MCAUSE, read MTVEC) and hands the returned handler address to fetch; on an MRET request it reads MEPC and hands back the return address. It sits between the core controller and the CSR unit. It drives the CSR unit's exception-mode port (`excp_int`, `operation`, `addr`, `data_wr`) and consumes its registered `data_out`, `error` and `done`.

## Interface
Parameters:
- MXLEN, 32, data/PC width
- ADDR_WIDTH, 12, CSR address width
- MTVEC_ADDR, 12'h305, MTVEC address
- MEPC_ADDR, 12'h341, MEPC address
- MCAUSE_ADDR, 12'h342, MCAUSE address

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- trap_req  in  1  level; trap pending, sampled only in IDLE
- trap_pc  in  MXLEN  faulting PC, captured on trap acceptance
- trap_cause  in  MXLEN  mcause encoding, captured on trap acceptance
- mret_req  in  1  level; MRET pending, sampled only in IDLE
- csr_excp  out  1  to CSR `excp_int`; high only in issue states
- csr_op  out  1  to CSR `operation`; 1=write (CSRRW), 0=read/set (CSRRS)
- csr_addr  out  ADDR_WIDTH  to CSR `addr`
- csr_wdata  out  MXLEN  to CSR `data_wr`
- csr_rdata  in  MXLEN  from CSR `data_out`, valid the cycle after a read issue
- csr_error  in  1  from CSR `error`, valid the cycle after any issue
- csr_done  in  1  from CSR `done`, expected 1 after an MEPC read
- busy  out  1  state != IDLE
- redirect_valid  out  1  one-cycle pulse, redirect_pc valid
- redirect_pc  out  MXLEN  handler or return address
- fault  out  1  one-cycle pulse, sequence aborted

## Operation
- States: IDLE, W_EPC, W_CAUSE, R_TVEC, WAIT_TVEC, R_EPC, WAIT_EPC, REDIRECT, FAULT.
- IDLE: trap_req=1 -> capture trap_pc/trap_cause, go W_EPC. Otherwise mret_req=1 -> R_EPC. Both high: trap wins, mret is not latched and the core must re-present it.
- W_EPC: csr_excp=1, op=1, addr=MEPC, wdata=captured pc -> W_CAUSE.
- W_CAUSE: op=1, addr=MCAUSE, wdata=captured cause. If csr_error=1 (EPC write rejected) -> FAULT, else -> R_TVEC.
- R_TVEC: op=0, addr=MTVEC, wdata=0. If csr_error=1 -> FAULT, else -> WAIT_TVEC.
- WAIT_TVEC: csr_excp=0. If csr_error=1 -> FAULT, else capture csr_rdata into redirect_pc -> REDIRECT.
- R_EPC: op=0, addr=MEPC, wdata=0 -> WAIT_EPC.
- WAIT_EPC: csr_error=1 or csr_done=0 -> FAULT; else capture csr_rdata -> REDIRECT.
- REDIRECT: redirect_valid=1 -> IDLE. FAULT: fault=1 -> IDLE; redirect_pc holds its previous value.
- csr_* outputs are a Moore decode of state. Outside issue states: csr_excp=0, op=0, addr=0, wdata=0.
- redirect_pc is passed through unmodified: no alignment masking and no +4 on MRET.
- trap_req/mret_req are ignored while busy. Captured pc/cause do not change mid-sequence.

## Timing
- Reset: state=IDLE. busy, redirect_valid, fault, csr_excp, csr_op = 0. csr_addr, csr_wdata, redirect_pc, captured pc/cause = 0.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs at reset values. No partial redirect or fault pulse.
- Trap: acceptance edge at cycle 0. W_EPC=c1, W_CAUSE=c2, R_TVEC=c3, WAIT_TVEC=c4, redirect_valid high in c5, IDLE in c6. Latency from acceptance to redirect is 5 cycles.
- MRET: R_EPC=c1, WAIT_EPC=c2, redirect_valid in c3.
- Error abort: fault is high the cycle after the error is sampled, then IDLE.
- A new request may be accepted in the cycle after REDIRECT or FAULT. Back-to-back spacing is 6 cycles for a trap, 4 for MRET.

## Test plan
- Reset then trap_req with trap_pc=0x0000_0100, trap_cause=0x2 -> CSR sees MEPC<=0x100 (c1), MCAUSE<=0x2 (c2), MTVEC read (c3). redirect_valid in c5 with redirect_pc=0x0000_00B4. busy high c1–c5.
- mret_req after the previous trap -> MEPC read in c1, csr_done=1 in c2, redirect_valid in c3 with redirect_pc=0x100.
- trap_req and mret_req both high in IDLE -> trap sequence only. mret_req held high then starts its sequence the cycle after REDIRECT.
- trap_cause=0x0000_000F (unmapped), CSR error on MTVEC read -> fault pulse in c5, no redirect_valid, redirect_pc unchanged.
- Bench CSR model forces csr_done=0 on MEPC read -> fault in c3, no redirect.
- rst_n pulsed low during R_TVEC -> all outputs 0 asynchronously, IDLE. A trap_req afterwards completes normally in 5 cycles.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: drives the CSR exception port through the trap (MEPC/MCAUSE write, MTVEC read) and MRET (MEPC read) sequences.
module trap_sequencer #(
  parameter int MXLEN = 32,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] MTVEC_ADDR = 12'h305,
  parameter logic [ADDR_WIDTH-1:0] MEPC_ADDR = 12'h341,
  parameter logic [ADDR_WIDTH-1:0] MCAUSE_ADDR = 12'h342
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_req,
  input  logic [MXLEN-1:0]      trap_pc,
  input  logic [MXLEN-1:0]      trap_cause,
  input  logic                  mret_req,
  output logic                  csr_excp,
  output logic                  csr_op,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [MXLEN-1:0]      csr_wdata,
  input  logic [MXLEN-1:0]      csr_rdata,
  input  logic                  csr_error,
  input  logic                  csr_done,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [MXLEN-1:0]      redirect_pc,
  output logic                  fault
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] W_EPC     = 4'd1;
  localparam logic [3:0] W_CAUSE   = 4'd2;
  localparam logic [3:0] R_TVEC    = 4'd3;
  localparam logic [3:0] WAIT_TVEC = 4'd4;
  localparam logic [3:0] R_EPC     = 4'd5;
  localparam logic [3:0] WAIT_EPC  = 4'd6;
  localparam logic [3:0] REDIRECT  = 4'd7;
  localparam logic [3:0] FAULT     = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [MXLEN-1:0] pc_q, pc_d, cause_q, cause_d, rpc_q, rpc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          state_d = W_EPC;
          pc_d    = trap_pc;
          cause_d = trap_cause;
        end else if (mret_req) state_d = R_EPC;
      end
      W_EPC:   state_d = W_CAUSE;
      // csr_error here reports on the issue from the previous state
      W_CAUSE: state_d = csr_error ? FAULT : R_TVEC;
      R_TVEC:  state_d = csr_error ? FAULT : WAIT_TVEC;
      WAIT_TVEC: begin
        state_d = csr_error ? FAULT : REDIRECT;
        rpc_d   = csr_error ? rpc_q : csr_rdata;
      end
      R_EPC: state_d = WAIT_EPC;
      WAIT_EPC: begin
        state_d = (csr_error || !csr_done) ? FAULT : REDIRECT;
        rpc_d   = (csr_error || !csr_done) ? rpc_q : csr_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      rpc_q   <= rpc_d;
    end
  end

  assign csr_excp       = state_q == W_EPC || state_q == W_CAUSE || state_q == R_TVEC || state_q == R_EPC;
  assign csr_op         = state_q == W_EPC || state_q == W_CAUSE;
  assign csr_addr       = (state_q == W_EPC || state_q == R_EPC) ? MEPC_ADDR :
                          state_q == W_CAUSE ? MCAUSE_ADDR :
                          state_q == R_TVEC ? MTVEC_ADDR : '0;
  assign csr_wdata      = state_q == W_EPC ? pc_q : state_q == W_CAUSE ? cause_q : '0;
  assign busy           = state_q != IDLE;
  assign redirect_valid = state_q == REDIRECT;
  assign fault          = state_q == FAULT;
  assign redirect_pc    = rpc_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized trap/MRET sequences against a behavioural CSR unit and expected-access model.
module tb_trap_sequencer;
  localparam logic [11:0] A_TVEC = 12'h305, A_EPC = 12'h341, A_CAUSE = 12'h342;
  logic        clk = 0, rst_n = 0, trap_req = 0, mret_req = 0;
  logic [31:0] trap_pc = 0, trap_cause = 0;
  logic        csr_excp, csr_op, csr_error, csr_done, busy, redirect_valid, fault;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, redirect_pc;
  logic [31:0] m_epc = 0, m_cause = 0, m_tvec = 0;
  logic [11:0] err_addr = 0;
  logic        err_en = 0, done_bad = 0;
  logic [31:0] exp_epc = 0, exp_rpc = 0;
  int          checks = 0, failures = 0;

  trap_sequencer dut (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_req(mret_req), .csr_excp(csr_excp), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error), .csr_done(csr_done),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Behavioural CSR unit: registered responses, rejected writes are not stored
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata <= 0;
      csr_error <= 0;
      csr_done  <= 0;
    end else begin
      csr_error <= csr_excp && err_en && csr_addr == err_addr;
      csr_done  <= csr_excp && !csr_op && !done_bad;
      csr_rdata <= (csr_excp && !csr_op) ? (csr_addr == A_TVEC ? m_tvec : csr_addr == A_EPC ? m_epc : 32'h0) : 32'h0;
      if (csr_excp && csr_op && !(err_en && csr_addr == err_addr)) begin
        if (csr_addr == A_EPC) m_epc <= csr_wdata;
        if (csr_addr == A_CAUSE) m_cause <= csr_wdata;
      end
    end
  end

  function automatic logic [63:0] vec(input logic b, rv, f, e, o, input logic [11:0] a, input logic [31:0] wd);
    return {15'h0, b, rv, f, e, o, a, wd};
  endfunction

  function automatic logic [63:0] obs();
    return vec(busy, redirect_valid, fault, csr_excp, csr_op, csr_addr, csr_wdata);
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // kind: 0 clean, 1 error on MTVEC read, 2 error on MEPC write
  task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tv, input int kind);
    logic [63:0] e [1:6];
    int last;
    m_tvec = tv;
    err_en = kind != 0;
    err_addr = kind == 2 ? A_EPC : A_TVEC;
    trap_pc = pc; trap_cause = cause; trap_req = 1;
    @(posedge clk); @(negedge clk);
    trap_req = 0; trap_pc = $urandom; trap_cause = $urandom;
    e[1] = vec(1, 0, 0, 1, 1, A_EPC, pc);
    e[2] = vec(1, 0, 0, 1, 1, A_CAUSE, cause);
    e[3] = vec(1, 0, 0, 1, 0, A_TVEC, 0);
    e[4] = vec(1, 0, 0, 0, 0, 0, 0);
    e[5] = vec(1, 1, 0, 0, 0, 0, 0);
    last = kind == 2 ? 3 : 5;
    if (kind != 0) e[last] = vec(1, 0, 1, 0, 0, 0, 0);
    e[last+1] = vec(0, 0, 0, 0, 0, 0, 0);
    if (kind != 2) exp_epc = pc;
    if (kind == 0) exp_rpc = tv;
    for (int c = 1; c <= last + 1; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("trap_k%0d_c%0d", kind, c), obs(), e[c]);
    end
    chk("trap_rpc", {32'h0, redirect_pc}, {32'h0, exp_rpc});
    chk("csr_mepc", {32'h0, m_epc}, {32'h0, exp_epc});
    err_en = 0;
  endtask

  task automatic run_mret(input bit ok);
    logic [63:0] e [1:4];
    done_bad = !ok;
    mret_req = 1;
    @(posedge clk); @(negedge clk);
    mret_req = 0;
    e[1] = vec(1, 0, 0, 1, 0, A_EPC, 0);
    e[2] = vec(1, 0, 0, 0, 0, 0, 0);
    e[3] = ok ? vec(1, 1, 0, 0, 0, 0, 0) : vec(1, 0, 1, 0, 0, 0, 0);
    e[4] = vec(0, 0, 0, 0, 0, 0, 0);
    if (ok) exp_rpc = exp_epc;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("mret_ok%0d_c%0d", ok, c), obs(), e[c]);
    end
    chk("mret_rpc", {32'h0, redirect_pc}, {32'h0, exp_rpc});
    done_bad = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", obs(), 64'h0);
    chk("reset_rpc", {32'h0, redirect_pc}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    run_trap(32'h100, 32'h2, 32'hB4, 0);
    run_mret(1);
    mret_req = 1;
    run_trap($urandom, $urandom, $urandom, 0);
    run_mret(1);
    run_trap($urandom, 32'hF, $urandom, 1);
    run_mret(0);
    run_trap($urandom, $urandom, $urandom, 2);
    run_mret(1);
    repeat (8) begin
      if ($urandom_range(1) == 1) run_trap($urandom, $urandom, $urandom, 0);
      else run_mret(1);
    end
    trap_pc = 32'h300; trap_cause = 32'h5; m_tvec = 32'h1234; trap_req = 1;
    @(posedge clk); @(negedge clk);
    trap_req = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_rtvec", obs(), vec(1, 0, 0, 1, 0, A_TVEC, 0));
    rst_n = 0;
    #1;
    chk("async_reset_outs", obs(), 64'h0);
    chk("async_reset_rpc", {32'h0, redirect_pc}, 64'h0);
    exp_rpc = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_trap(32'h200, 32'h3, $urandom, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
